data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-port arbiter that shares the single-ported data memory (`data_mem`) between the processor load/store port (port A) and a secondary master such as a DMA or debug loader (port B). It captures one request at a time, sequences the memory's request/stall protocol, holds address and write data stable for the whole access, and returns read data with a one-cycle completion pulse to the granted requester. It sits between the load/store stage, the secondary master and `data_mem`, and is the only driver of the memory's request inputs.

## Interface
- `FIXED_PRIO`, 0 — 0: round-robin between A and B; 1: A always wins when both request.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `a_req`, `b_req`  in  1  request; held high until the matching `*_ready`.
- `a_we`, `b_we`  in  1  1 = write, 0 = read.
- `a_addr`, `b_addr`  in  32  byte address.
- `a_wdata`, `b_wdata`  in  32  write data.
- `a_sign_mask`, `b_sign_mask`  in  4  size/sign code, passed to memory unchanged.
- `a_ready`, `b_ready`  out  1  one-cycle completion pulse.
- `a_rdata`, `b_rdata`  out  32  read data, valid while `*_ready` is high, held afterwards.
- `mem_addr`  out  32  memory address.
- `mem_write_data`  out  32  memory write data.
- `mem_memwrite`, `mem_memread`  out  1  memory request strobes.
- `mem_sign_mask`  out  4  memory size/sign code.
- `mem_read_data`  in  32  memory read data.
- `mem_stall`  in  1  memory busy (`clk_stall` of `data_mem`).

## Operation
- Reset: state IDLE; every output 0; `last_grant` = B, so A wins the first tie.
- Grant latch: on grant, copy the winner's we/addr/wdata/sign_mask into internal registers and record the winner in `owner`. `mem_addr`, `mem_write_data` and `mem_sign_mask` are driven from these registers and stay constant from ISSUE through WAIT.
- States:
  - IDLE: grant only if `mem_stall`=0 and at least one eligible request exists, then go to ISSUE.
  - A port is ineligible in any cycle where its own `*_ready` is high. This absorbs the requester's req-drop cycle.
  - Arbitration: if only one port requests, it wins. If both request, `FIXED_PRIO`=1 picks A; otherwise the port opposite `last_grant` wins. Update `last_grant` to the winner.
  - ISSUE (1 cycle): assert `mem_memread` = ~we or `mem_memwrite` = we, never both, then go to WAIT.
  - WAIT: strobes low, address and data held. When `mem_stall`=0 is sampled, register `mem_read_data` into the owner's `*_rdata` (reads only; writes leave `*_rdata` unchanged). Pulse the owner's `*_ready` in the next cycle, then return to IDLE.
- `*_rdata` of the non-owner port never changes.
- Address 0x2000 (LED register) and all other addresses are treated identically; no decoding is done here.

## Timing
- Cycle n: IDLE samples `a_req`=1 and grants. Cycle n+1: ISSUE, strobe high. Cycle n+2: WAIT, `mem_stall`=1. Cycle n+3: WAIT sees `mem_stall`=0. Cycle n+4: `*_ready`=1 and the arbiter is back in IDLE.
- Latency from request to ready is 4 cycles. Peak throughput is one access per 4 cycles.
- A new grant can occur in cycle n+4, to the other port only. The same port can be granted again at n+5 at the earliest.
- A request arriving while busy waits. It is never dropped and never merged with another request.
- Simultaneous A and B requests in round-robin mode alternate grants A, B, A, B.
- `mem_stall` high in IDLE (memory still busy, e.g. after reset): no grant until it falls.
- Async reset mid-access: outputs clear immediately and any pending `*_ready` is lost. `data_mem` finishes its own access, and the arbiter waits in IDLE for `mem_stall`=0. The requester must re-issue.
- Input changes on a granted port after the grant have no effect until that access completes.

## Test plan
- Single read on A: `a_addr`=0x1004, `a_we`=0, memory returns 0xDEADBEEF → `mem_memread` high exactly at n+1, `a_ready` pulse at n+4, `a_rdata`=0xDEADBEEF, `b_ready` stays 0.
- Single write on B: `b_addr`=0x1010, `b_wdata`=0x12345678, `b_sign_mask`=0b0100 → one-cycle `mem_memwrite`. `mem_addr`/`mem_write_data` stay stable from n+1 to n+3, then `b_ready` pulses and `b_rdata` is unchanged.
- Contention with `FIXED_PRIO`=0 and both ports holding req for 4 accesses → grant order A, B, A, B, each completion 4 cycles apart.
- Contention with `FIXED_PRIO`=1 and `a_req` reasserted every time it is eligible → B is granted only in A's ready cycles. B completes 4 cycles after each A.
- `mem_stall` forced high for 3 cycles with `a_req`=1 in IDLE → no strobe until `mem_stall` falls; grant in the first cycle it is sampled low.
- `rst_n` pulsed low at n+2 of an A read → all outputs 0 asynchronously, no `a_ready`. After release and `mem_stall`=0, a re-issued request completes normally in 4 cycles.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter sharing the single-ported data memory
module data_mem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_sign_mask,
  output logic        a_ready,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_sign_mask,
  output logic        b_ready,
  output logic [31:0] b_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_stall
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]  state;
  logic        owner;       // 0 = port A, 1 = port B
  logic        last_grant;  // 0 = port A, 1 = port B
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;

  logic a_elig;
  logic b_elig;
  logic grant;
  logic grant_b;

  // Eligibility and winner selection; a port in its ready cycle is still
  // showing the old request, so it is masked out for that cycle.
  always_comb begin
    a_elig  = a_req & ~a_ready;
    b_elig  = b_req & ~b_ready;
    grant   = (state == ST_IDLE) & ~mem_stall & (a_elig | b_elig);
    grant_b = b_elig;
    if (a_elig && b_elig) begin
      grant_b = FIXED_PRIO ? 1'b0 : ~last_grant;
    end
  end

  // Access sequencer and grant latch; the latched request stays put until IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      mask_q     <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state      <= ST_ISSUE;
            owner      <= grant_b;
            last_grant <= grant_b;
            we_q       <= grant_b ? b_we        : a_we;
            addr_q     <= grant_b ? b_addr      : a_addr;
            wdata_q    <= grant_b ? b_wdata     : a_wdata;
            mask_q     <= grant_b ? b_sign_mask : a_sign_mask;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (!mem_stall) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Completion: capture read data for the owner and pulse its ready for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ready <= 1'b0;
      b_ready <= 1'b0;
      a_rdata <= 32'd0;
      b_rdata <= 32'd0;
    end else begin
      a_ready <= 1'b0;
      b_ready <= 1'b0;
      if (state == ST_WAIT && !mem_stall) begin
        if (owner) begin
          b_ready <= 1'b1;
          if (!we_q) begin
            b_rdata <= mem_read_data;
          end
        end else begin
          a_ready <= 1'b1;
          if (!we_q) begin
            a_rdata <= mem_read_data;
          end
        end
      end
    end
  end

  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = mask_q;
  assign mem_memread    = (state == ST_ISSUE) & ~we_q;
  assign mem_memwrite   = (state == ST_ISSUE) & we_q;

endmodule
